// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone machine timer: register map, CTRL/STATUS bits, FSM states.
// Used by wb_timer_slave and wb_timer_counter; the optional prescaler is WB_TIMER_PRESCALER_EN.
package wb_timer_pkg;

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_STATUS      = 3'd5;
    localparam logic [2:0] REG_PRESCALE    = 3'd6;
    localparam logic [2:0] REG_RESERVED    = 3'd7;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STATUS_PEND_BIT = 0;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } wb_state_t;

    typedef logic [63:0] mtime_t;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_timer_counter.sv
// 64-bit free-running mtime register with a 32-bit half-word load port.
// With WB_TIMER_PRESCALER_EN defined, ticks come from a 16-bit divider compared to PRESCALE.
module wb_timer_counter
    import wb_timer_pkg::*;
(
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_EN,
    input  logic        i_LOAD_LO,
    input  logic        i_LOAD_HI,
    input  logic [31:0] i_LOAD_DATA,
`ifdef WB_TIMER_PRESCALER_EN
    input  logic [15:0] i_PRESCALE,
    input  logic        i_PRESCALE_WR,
`endif
    output mtime_t      o_MTIME
);

    mtime_t mtime_q, mtime_d;
    logic   tick;

`ifdef WB_TIMER_PRESCALER_EN
    logic [15:0] div_q, div_d;

    assign tick = i_EN && (div_q == i_PRESCALE);

    // Holding the divider at zero while disabled gives the clear on an EN 0->1 edge.
    always_comb begin
        div_d = div_q + 16'd1;
        if (!i_EN || i_PRESCALE_WR || tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = i_EN;
`endif

    // A bus load wins over the increment in the same cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (i_LOAD_LO) begin
            mtime_d[31:0] = i_LOAD_DATA;
        end else if (i_LOAD_HI) begin
            mtime_d[63:32] = i_LOAD_DATA;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            mtime_q <= '0;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    assign o_MTIME = mtime_q;

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone classic slave: 64-bit machine timer with compare, level IRQ and one-cycle registered ACK.
// Define WB_TIMER_PRESCALER_EN to enable the PRESCALE register (index 6) and tick divider.
module wb_timer_slave
    import wb_timer_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_WE,
    input  logic [3:0]            i_SEL,
    input  logic                  i_STB,
    input  logic                  i_CYC,
    output logic                  o_ACK,
    input  logic                  i_TAGN,
    output logic                  o_TAGN,
    output logic                  o_IRQ
);

    wb_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rd_data;
    logic                  tag_q, tag_d;
    mtime_t                cmp_q, cmp_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic                  pend_q, pend_d;
    logic                  irq_q, irq_d;
    mtime_t                mtime;
    logic                  take, wr, w1c, load_lo, load_hi;
    logic [2:0]            idx;
    logic [31:0]           load_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{i_ADDR[ADDR_WIDTH-1:5], i_ADDR[1:0]};

    // Requests are taken only in IDLE; writes commit on the same edge that raises o_ACK.
    assign idx     = i_ADDR[4:2];
    assign take    = (state_q == IDLE) && i_CYC && i_STB;
    assign wr      = take && i_WE;
    assign w1c     = wr && (idx == REG_STATUS) && i_SEL[0] && i_DATA[STATUS_PEND_BIT];
    assign load_lo = wr && (idx == REG_MTIME_LO);
    assign load_hi = wr && (idx == REG_MTIME_HI);
    assign load_data = lane_merge(load_lo ? mtime[31:0] : mtime[63:32], i_DATA, i_SEL);

`ifdef WB_TIMER_PRESCALER_EN
    logic [15:0] ps_q, ps_d;
    logic        ps_wr;

    assign ps_wr = wr && (idx == REG_PRESCALE);

    always_comb begin
        ps_d = ps_q;
        if (ps_wr) begin
            if (i_SEL[0]) ps_d[7:0]  = i_DATA[7:0];
            if (i_SEL[1]) ps_d[15:8] = i_DATA[15:8];
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`endif

    wb_timer_counter u_counter (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_EN          (ctrl_q[CTRL_EN_BIT]),
        .i_LOAD_LO     (load_lo),
        .i_LOAD_HI     (load_hi),
        .i_LOAD_DATA   (load_data),
`ifdef WB_TIMER_PRESCALER_EN
        .i_PRESCALE    (ps_q),
        .i_PRESCALE_WR (ps_wr),
`endif
        .o_MTIME       (mtime)
    );

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_MTIME_LO:    rd_data = mtime[31:0];
            REG_MTIME_HI:    rd_data = mtime[63:32];
            REG_MTIMECMP_LO: rd_data = cmp_q[31:0];
            REG_MTIMECMP_HI: rd_data = cmp_q[63:32];
            REG_CTRL:        rd_data = {30'd0, ctrl_q};
            REG_STATUS:      rd_data = {31'd0, pend_q};
`ifdef WB_TIMER_PRESCALER_EN
            REG_PRESCALE:    rd_data = {16'd0, ps_q};
`endif
            default:         rd_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_CYC && i_STB) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmp_d  = cmp_q;
        ctrl_d = ctrl_q;
        if (wr) begin
            case (idx)
                REG_MTIMECMP_LO: cmp_d[31:0]  = lane_merge(cmp_q[31:0], i_DATA, i_SEL);
                REG_MTIMECMP_HI: cmp_d[63:32] = lane_merge(cmp_q[63:32], i_DATA, i_SEL);
                REG_CTRL:        if (i_SEL[0]) ctrl_d = i_DATA[1:0];
                default:         ;
            endcase
        end
    end

    // A compare hit outranks a W1C clear in the same cycle.
    always_comb begin
        pend_d = pend_q;
        if (mtime >= cmp_q) begin
            pend_d = 1'b1;
        end else if (w1c) begin
            pend_d = 1'b0;
        end
        irq_d  = pend_q && ctrl_q[CTRL_IRQ_EN_BIT];
        data_d = (take && !i_WE) ? rd_data : '0;
        tag_d  = take ? i_TAGN : 1'b0;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            tag_q   <= 1'b0;
            cmp_q   <= MTIMECMP_RST;
            ctrl_q  <= '0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign o_ACK  = (state_q == ACK);
    assign o_DATA = data_q;
    assign o_TAGN = tag_q;
    assign o_IRQ  = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Bench for wb_timer_slave: directed bus accesses push expected responses; a monitor checks each ACK.
// Optionally exercises the prescaler when WB_TIMER_PRESCALER_EN is defined.
module tb_wb_timer_slave;

    localparam int W = 66;  // {is_read, tag, ack_cycle[31:0], data[31:0]}

    localparam logic [2:0] R_MTIME_LO = 3'd0;
    localparam logic [2:0] R_MTIME_HI = 3'd1;
    localparam logic [2:0] R_CMP_LO   = 3'd2;
    localparam logic [2:0] R_CMP_HI   = 3'd3;
    localparam logic [2:0] R_CTRL     = 3'd4;
    localparam logic [2:0] R_STATUS   = 3'd5;
    localparam logic [2:0] R_PRESCALE = 3'd6;
    localparam logic [2:0] R_RSVD     = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        we, stb, cyc, tag_in, ack, tag_out, irq;
    logic [3:0]  sel;

    int unsigned cyc_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_timer_slave dut (
        .i_CLK  (clk),
        .i_RST  (rst),
        .i_ADDR (addr),
        .i_DATA (wdata),
        .o_DATA (rdata),
        .i_WE   (we),
        .i_SEL  (sel),
        .i_STB  (stb),
        .i_CYC  (cyc),
        .o_ACK  (ack),
        .i_TAGN (tag_in),
        .o_TAGN (tag_out),
        .o_IRQ  (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic bus_start(input logic [2:0] idx, input logic w, input logic [31:0] d,
                             input logic [3:0] s, input logic t, input logic [31:0] exp_rd);
        addr = {27'd0, idx, 2'b00};
        we = w; wdata = d; sel = s; tag_in = t; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back({~w, t, cyc_cnt + 32'd1, exp_rd});
    endtask

    task automatic bus_stop();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; tag_in = 1'b0; sel = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
        bus_start(idx, 1'b1, d, s, 1'b0, 32'd0);
        idle(1);
        bus_stop();
        idle(1);
    endtask

    task automatic rd_reg(input logic [2:0] idx, input logic [31:0] exp_rd);
        bus_start(idx, 1'b0, 32'd0, 4'h0, 1'b0, exp_rd);
        idle(1);
        bus_stop();
        idle(1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: ack at cycle %0d, required no ack", cyc_cnt);
            end else begin
                e = exp_q.pop_front();
                check("ack_cycle", cyc_cnt, e[63:32]);
                check("ack_tag", {31'd0, tag_out}, {31'd0, e[64]});
                if (e[65]) check("rd_data", rdata, e[31:0]);
            end
        end else begin
            check("data_zero_without_ack", rdata, 32'd0);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: run did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; addr = '0; wdata = '0; sel = '0;
        we = 1'b0; stb = 1'b0; cyc = 1'b0; tag_in = 1'b0;
        idle(3);
        rst = 1'b0;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_tag", {31'd0, tag_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Compare register reset value
        rd_reg(R_CMP_HI, 32'hFFFF_FFFF);
        check("irq_idle", {31'd0, irq}, 32'd0);

        // Enable at write edge E; read sampled at E+11 sees 11
        wr_reg(R_CTRL, 32'd1, 4'hF);
        idle(10);
        rd_reg(R_MTIME_LO, 32'd11);

        // Carry from low to high word; lane-selective write
        wr_reg(R_CTRL, 32'd0, 4'hF);
        wr_reg(R_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        wr_reg(R_MTIME_HI, 32'd0, 4'hF);
        wr_reg(R_CTRL, 32'd1, 4'hF);
        idle(3);
        rd_reg(R_MTIME_HI, 32'd1);
        rd_reg(R_MTIME_LO, 32'd5);
        wr_reg(R_CMP_LO, 32'h0000_AB00, 4'b0010);
        rd_reg(R_CMP_LO, 32'hFFFF_ABFF);
        rd_reg(R_CMP_HI, 32'hFFFF_FFFF);

        // Compare / IRQ / W1C priority
        wr_reg(R_CTRL, 32'd0, 4'hF);
        wr_reg(R_MTIME_LO, 32'd0, 4'hF);
        wr_reg(R_MTIME_HI, 32'd0, 4'hF);
        wr_reg(R_CMP_HI, 32'd0, 4'hF);
        wr_reg(R_CMP_LO, 32'd20, 4'hF);
        rd_reg(R_STATUS, 32'd0);
        wr_reg(R_CTRL, 32'd3, 4'hF);
        check("irq_before_match", {31'd0, irq}, 32'd0);
        idle(30);
        check("irq_after_match", {31'd0, irq}, 32'd1);
        rd_reg(R_STATUS, 32'd1);
        wr_reg(R_STATUS, 32'd1, 4'hF);
        rd_reg(R_STATUS, 32'd1);
        check("irq_held_over_w1c", {31'd0, irq}, 32'd1);
        rd_reg(R_CTRL, 32'd3);
        wr_reg(R_CMP_HI, 32'hFFFF_FFFF, 4'hF);
        wr_reg(R_STATUS, 32'd1, 4'hF);
        idle(2);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_reg(R_STATUS, 32'd0);

        // Strobe held 4 cycles: ACKs one and three cycles later, tag returned
        bus_start(R_RSVD, 1'b0, 32'd0, 4'h0, 1'b1, 32'd0);
        exp_q.push_back({1'b1, 1'b1, cyc_cnt + 32'd3, 32'd0});
        idle(4);
        bus_stop();
        idle(1);

`ifndef WB_TIMER_PRESCALER_EN
        wr_reg(R_PRESCALE, 32'h0000_FFFF, 4'hF);
        rd_reg(R_PRESCALE, 32'd0);
`endif

        // Reset in the ACK cycle of a compare write
        bus_start(R_CMP_LO, 1'b1, 32'd5, 4'hF, 1'b0, 32'd0);
        idle(1);
        bus_stop();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("ack_dropped_by_rst", {31'd0, ack}, 32'd0);
        rd_reg(R_CMP_LO, 32'hFFFF_FFFF);
        rd_reg(R_CMP_HI, 32'hFFFF_FFFF);
        rd_reg(R_CTRL, 32'd0);
        rd_reg(R_MTIME_LO, 32'd0);
        rd_reg(R_STATUS, 32'd0);

`ifdef WB_TIMER_PRESCALER_EN
        // PRESCALE=3: enable at edge E, mtime after E+n is n/4
        wr_reg(R_PRESCALE, 32'd3, 4'hF);
        rd_reg(R_PRESCALE, 32'd3);
        wr_reg(R_CTRL, 32'd1, 4'hF);
        idle(10);
        rd_reg(R_MTIME_LO, 32'd2);
        idle(4);
        rd_reg(R_MTIME_LO, 32'd4);
`endif

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
